// File: rtl/wb_dma_pkg.sv
// Shared types and default constants for the Wishbone DMA initiator and its watchdog.
package wb_dma_pkg;

  localparam int unsigned LEN_W_DEF          = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
  localparam logic [3:0]  WB_SEL_WORD        = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    FINISH  = 3'd5
  } dma_state_t;

  // States in which the initiator owns the bus and can be aborted or time out.
  function automatic logic is_bus_state(input dma_state_t s);
    return (s == RD_REQ) || (s == RD_WAIT) || (s == WR_REQ) || (s == WR_WAIT);
  endfunction

endpackage

// File: rtl/wb_dma_if.sv
// Pipelined Wishbone bus between the DMA initiator (master) and a target (slave).
interface wb_dma_if;

  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic        i_wb_stall;
  logic [31:0] i_wb_data;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    input  i_wb_ack, i_wb_stall, i_wb_data
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
    output i_wb_ack, i_wb_stall, i_wb_data
  );

endinterface

// File: rtl/wb_dma_watchdog.sv
// Counts cycles the initiator has spent in its current bus state and flags expiry
// on the TIMEOUT_CYCLES-th cycle. Only instantiated when WB_DMA_TIMEOUT_EN is defined.
module wb_dma_watchdog
  import wb_dma_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  dma_state_t state,
  output logic       expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  dma_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] elapsed;

  // A state change restarts the count in the same cycle it becomes visible.
  assign elapsed = (state != state_q) ? '0 : cnt_q;
  assign expired = is_bus_state(state) && (elapsed == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state;
      cnt_q   <= is_bus_state(state) ? elapsed + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/wb_dma_initiator.sv
// Word-copy DMA engine: reads one word, writes it back out, repeats for i_len words.
// Optional bus watchdog enabled by defining WB_DMA_TIMEOUT_EN.
module wb_dma_initiator
  import wb_dma_pkg::*;
#(
  parameter int unsigned LEN_W          = LEN_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [31:0]      i_src,
  input  logic [31:0]      i_dst,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [LEN_W-1:0] o_count,
  wb_dma_if.master         wb
);

  typedef struct packed {
    dma_state_t       state;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] count;
    logic             busy;
    logic             done;
    logic             err;
    logic             cyc;
    logic             stb;
    logic             we;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [3:0]       sel;
  } regs_t;

  regs_t            r_q;
  regs_t            r_d;
  logic             accept;
  logic [LEN_W-1:0] count_inc;
  logic             timeout_hit;

`ifdef WB_DMA_TIMEOUT_EN
  wb_dma_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .state   (r_q.state),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every field starts from its held value so no path can infer a latch.
    r_d       = r_q;
    r_d.done  = 1'b0;
    r_d.err   = 1'b0;
    accept    = r_q.stb && !wb.i_wb_stall;
    count_inc = r_q.count + LEN_W'(1);

    case (r_q.state)
      IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            r_d.src   = i_src;
            r_d.dst   = i_dst;
            r_d.len   = i_len;
            r_d.count = '0;
            r_d.busy  = 1'b1;
            r_d.cyc   = 1'b1;
            r_d.stb   = 1'b1;
            r_d.we    = 1'b0;
            r_d.addr  = i_src;
            r_d.sel   = WB_SEL_WORD;
            r_d.state = RD_REQ;
          end else begin
            r_d.done  = 1'b1;
            r_d.state = FINISH;
          end
        end
      end
      RD_REQ: begin
        if (accept) begin
          r_d.stb   = 1'b0;
          r_d.state = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (wb.i_wb_ack) begin
          r_d.data  = wb.i_wb_data;
          r_d.stb   = 1'b1;
          r_d.we    = 1'b1;
          r_d.addr  = r_q.dst;
          r_d.state = WR_REQ;
        end
      end
      WR_REQ: begin
        if (accept) begin
          r_d.stb   = 1'b0;
          r_d.state = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (wb.i_wb_ack) begin
          r_d.count = count_inc;
          r_d.src   = r_q.src + 32'd4;
          r_d.dst   = r_q.dst + 32'd4;
          if (count_inc < r_q.len) begin
            r_d.stb   = 1'b1;
            r_d.we    = 1'b0;
            r_d.addr  = r_q.src + 32'd4;
            r_d.state = RD_REQ;
          end else begin
            r_d.cyc   = 1'b0;
            r_d.we    = 1'b0;
            r_d.busy  = 1'b0;
            r_d.done  = 1'b1;
            r_d.state = FINISH;
          end
        end
      end
      FINISH:  r_d.state = IDLE;
      default: r_d.state = IDLE;
    endcase

    // Abort and timeout override everything above, including a write ack in the same cycle.
    if (is_bus_state(r_q.state) && (i_abort || timeout_hit)) begin
      r_d.state = FINISH;
      r_d.count = r_q.count;
      r_d.src   = r_q.src;
      r_d.dst   = r_q.dst;
      r_d.cyc   = 1'b0;
      r_d.stb   = 1'b0;
      r_d.we    = 1'b0;
      r_d.busy  = 1'b0;
      r_d.done  = 1'b1;
      r_d.err   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: non-blocking updates so every register samples pre-edge values.
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign o_busy       = r_q.busy;
  assign o_done       = r_q.done;
  assign o_err        = r_q.err;
  assign o_count      = r_q.count;
  assign wb.o_wb_cyc  = r_q.cyc;
  assign wb.o_wb_stb  = r_q.stb;
  assign wb.o_wb_we   = r_q.we;
  assign wb.o_wb_addr = r_q.addr;
  assign wb.o_wb_data = r_q.data;
  assign wb.o_wb_sel  = r_q.sel;

endmodule

// File: tb/tb_wb_dma_initiator.sv
// Randomized bench for wb_dma_initiator: a Wishbone responder with random stall/latency,
// a word-copy reference model, and directed corner cases.
module tb_wb_dma_initiator;
  import wb_dma_pkg::*;

  localparam int LEN_W = 16;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [31:0]      src = '0;
  logic [31:0]      dst = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, err;
  logic [LEN_W-1:0] count;

  wb_dma_if bus ();

  wb_dma_initiator #(
    .LEN_W          (LEN_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_abort (abort),
    .i_src   (src),
    .i_dst   (dst),
    .i_len   (len),
    .o_busy  (busy),
    .o_done  (done),
    .o_err   (err),
    .o_count (count),
    .wb      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Source memory contents as a pure function of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Responder configuration and observation state.
  int          stall_mode = 0;   // 0: none, 1: three cycles per request, 2: random 0..3
  int          max_lat    = 0;
  bit          never_ack  = 1'b0;
  int          abort_at_ack = 0;
  int          ack_num;
  bit          pend;
  int          pend_lat;
  logic [31:0] pend_addr, pend_data;
  logic        pend_we;
  int          stall_left;
  bit          stalled_prev;
  logic [31:0] prev_addr, prev_data;
  logic        prev_we;
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          cyc_gap, unstable, multi_out, cyc_seen, stb_no_cyc;

  initial begin : responder
    bus.i_wb_ack   = 1'b0;
    bus.i_wb_stall = 1'b0;
    bus.i_wb_data  = '0;
    forever begin
      @(negedge clk);
      bus.i_wb_ack  = 1'b0;
      bus.i_wb_data = $urandom;
      abort         = 1'b0;
      if (!rst_n || !bus.o_wb_cyc) begin
        if (rst_n && busy) cyc_gap++;
        if (rst_n && bus.o_wb_stb) stb_no_cyc++;
        pend = 1'b0;
        stall_left = 0;
        stalled_prev = 1'b0;
        bus.i_wb_stall = 1'b0;
        continue;
      end
      cyc_seen++;
      if (pend && !never_ack) begin
        if (pend_lat == 0) begin
          bus.i_wb_ack = 1'b1;
          pend = 1'b0;
          ack_num++;
          if (pend_we) begin
            wr_addr_log.push_back(pend_addr);
            wr_data_log.push_back(pend_data);
          end else begin
            bus.i_wb_data = mem_word(pend_addr);
            rd_log.push_back(pend_addr);
          end
          if (ack_num == abort_at_ack) abort = 1'b1;
        end else begin
          pend_lat--;
        end
      end
      if (bus.o_wb_stb) begin
        if (pend) multi_out++;
        if (stalled_prev && (bus.o_wb_addr !== prev_addr || bus.o_wb_we !== prev_we ||
                             (bus.o_wb_we && bus.o_wb_data !== prev_data)))
          unstable++;
        if (!stalled_prev)
          stall_left = (stall_mode == 0) ? 0 : (stall_mode == 1) ? 3 : $urandom_range(0, 3);
        if (stall_left > 0) begin
          bus.i_wb_stall = 1'b1;
          stall_left--;
          stalled_prev = 1'b1;
          prev_addr = bus.o_wb_addr;
          prev_data = bus.o_wb_data;
          prev_we   = bus.o_wb_we;
        end else begin
          bus.i_wb_stall = 1'b0;
          stalled_prev = 1'b0;
          pend      = 1'b1;
          pend_lat  = $urandom_range(0, max_lat);
          pend_addr = bus.o_wb_addr;
          pend_data = bus.o_wb_data;
          pend_we   = bus.o_wb_we;
          if (bus.o_wb_sel !== WB_SEL_WORD) unstable++;
        end
      end else begin
        if (stalled_prev) unstable++;
        bus.i_wb_stall = 1'b0;
        stalled_prev = 1'b0;
      end
    end
  end

  task automatic clear_obs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    ack_num = 0;
    cyc_gap = 0; unstable = 0; multi_out = 0; cyc_seen = 0; stb_no_cyc = 0;
  endtask

  // Launch one copy and compare everything against the word-copy model.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int abort_n, input string tag);
    bit got_done;
    int exp_count;
    exp_count = (abort_n == 0) ? n : (abort_n - 1) / 2;
    @(negedge clk);
    clear_obs();
    abort_at_ack = abort_n;
    src = s; dst = d; len = LEN_W'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      check({tag, "_zero_done"}, done, 1'b1);
      check({tag, "_zero_err"}, err, 1'b0);
      check({tag, "_zero_busy"}, busy, 1'b0);
      @(negedge clk);
      check({tag, "_zero_pulse"}, done, 1'b0);
      repeat (3) @(negedge clk);
      check({tag, "_zero_cyc_seen"}, cyc_seen, 0);
      check({tag, "_zero_stb"}, stb_no_cyc, 0);
      return;
    end
    check({tag, "_start_cyc_stb_busy"}, {bus.o_wb_cyc, bus.o_wb_stb, busy}, 3'b111);
    check({tag, "_start_addr"}, bus.o_wb_addr, s);
    got_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      // Junk start requests while busy must be ignored.
      start = ($urandom_range(0, 7) == 0);
      src   = $urandom;
      dst   = $urandom;
      len   = LEN_W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, got_done, 1'b1);
    check({tag, "_err"}, err, (abort_n != 0));
    check({tag, "_cyc_end"}, bus.o_wb_cyc, 1'b0);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_count"}, count, exp_count);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    if (abort_n == 0) begin
      check({tag, "_rd_n"}, rd_log.size(), n);
      check({tag, "_wr_n"}, wr_addr_log.size(), n);
    end
    for (int i = 0; i < exp_count; i++) begin
      if (i < rd_log.size())
        check($sformatf("%s_rd%0d", tag, i), rd_log[i], s + 32'(4 * i));
      if (i < wr_addr_log.size()) begin
        check($sformatf("%s_wa%0d", tag, i), wr_addr_log[i], d + 32'(4 * i));
        check($sformatf("%s_wd%0d", tag, i), wr_data_log[i], mem_word(s + 32'(4 * i)));
      end
    end
    check({tag, "_cyc_gap"}, cyc_gap, 0);
    check({tag, "_stable"}, unstable, 0);
    check({tag, "_one_outstanding"}, multi_out, 0);
    abort_at_ack = 0;
  endtask

  initial begin : watchdog_guard
    #2_000_000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin : main
    int n, ab;
    bit got_done;
    int wait_cycles, dones;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cyc", bus.o_wb_cyc, 1'b0);
    check("rst_stb", bus.o_wb_stb, 1'b0);
    check("rst_we", bus.o_wb_we, 1'b0);
    check("rst_addr", bus.o_wb_addr, 32'h0);
    check("rst_data", bus.o_wb_data, 32'h0);
    check("rst_sel", bus.o_wb_sel, 4'h0);
    check("rst_flags", {busy, done, err}, 3'b000);
    check("rst_count", count, 0);
    rst_n = 1'b1;

    stall_mode = 0; max_lat = 0;
    run_xfer(32'h0000_0100, 32'h0000_0200, 4, 0, "basic");
    stall_mode = 1;
    run_xfer(32'h0000_0100, 32'h0000_0200, 4, 0, "stall3");
    stall_mode = 0;
    run_xfer(32'h0000_0100, 32'h0000_0200, 0, 0, "len0");
    run_xfer(32'hFFFF_FFFC, 32'h0000_0300, 2, 0, "wrap");
    check("wrap_second_rd", (rd_log.size() > 1) ? rd_log[1] : 32'hDEAD_BEEF, 32'h0000_0000);
    run_xfer(32'h0000_1000, 32'h0000_2000, 8, 6, "abort_w3");

    for (int t = 0; t < 12; t++) begin
      stall_mode = 2;
      max_lat = $urandom_range(0, 3);
      n  = $urandom_range(1, 6);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * n) : 0;
      run_xfer($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, n, ab,
               $sformatf("rand%0d", t));
    end

    // Reset in the middle of a transfer drops the bus at once and never pulses done.
    stall_mode = 1; max_lat = 2;
    @(negedge clk);
    clear_obs();
    src = 32'h40; dst = 32'h80; len = LEN_W'(8); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_pre_cyc", bus.o_wb_cyc, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cyc_stb", {bus.o_wb_cyc, bus.o_wb_stb}, 2'b00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", count, 0);
    check("midrst_addr", bus.o_wb_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_idle_cyc", bus.o_wb_cyc, 1'b0);
    stall_mode = 0; max_lat = 0;
    run_xfer(32'h0000_0500, 32'h0000_0600, 3, 0, "post_rst");

`ifdef WB_DMA_TIMEOUT_EN
    // Never-acking target: the watchdog must end the transfer after TO wait cycles.
    never_ack = 1'b1;
    @(negedge clk);
    clear_obs();
    src = 32'h10; dst = 32'h20; len = LEN_W'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_done = 1'b0;
    wait_cycles = 0;
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (bus.o_wb_cyc && !bus.o_wb_stb) wait_cycles++;
      @(negedge clk);
    end
    check("timeout_done", got_done, 1'b1);
    check("timeout_err", err, 1'b1);
    check("timeout_cyc", bus.o_wb_cyc, 1'b0);
    check("timeout_wait_cycles", wait_cycles, TO);
    never_ack = 1'b0;
    repeat (2) @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
